// File: rtl/msk_rnd_pkg.sv
// Shared constants, FSM state type and width helper for the masked-multiplier randomness generator.
// Purely declarative: no latency, no flow control.
package msk_rnd_pkg;

   localparam int LFSR_W = 32;
   // x^32 + x^22 + x^2 + x + 1 in right-shift Galois form
   localparam logic [LFSR_W-1:0] LFSR_TAPS     = 32'h8020_0003;
   // An all-zero Galois LFSR is stuck forever, so a zero seed is replaced by this value
   localparam logic [LFSR_W-1:0] SEED_ZERO_FIX = 32'h0000_0001;

   typedef enum logic {
      SEED = 1'b0,
      RUN  = 1'b1
   } rnd_state_e;

   function automatic int rnd_width(input int ref_n_rnd, input int dom_rnd);
      return 4 * (ref_n_rnd + dom_rnd);
   endfunction

endpackage

// File: rtl/msk_lfsr32_lane.sv
// One 32-bit Galois LFSR lane; load has priority over step and a new value appears one edge later.
// No backpressure: the owner decides each cycle whether the lane loads, steps or holds.
module msk_lfsr32_lane
   import msk_rnd_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step,
   output logic              lsb
);

   logic [LFSR_W-1:0] state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= {LFSR_W{1'b0}};
      end else if (load) begin
         state_q <= (load_val == {LFSR_W{1'b0}}) ? SEED_ZERO_FIX : load_val;
      end else if (step) begin
         state_q <= (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
      end
   end

   assign lsb = state_q[0];

endmodule

// File: rtl/msk_rnd_gen_g16mul.sv
// Randomness source for the HPC1 GF(16) multiplier: serial seed load, then one fresh bit per lane per enabled cycle.
// rnd follows each enabled edge by one cycle; seed words are taken whenever seed_ready is high (SEED state).
module msk_rnd_gen_g16mul
   import msk_rnd_pkg::*;
#(
   parameter  int d             = 2,
   parameter  int REF_N_RND     = d * (d - 1) / 2,
   parameter  int DOM_RND       = d * (d - 1) / 2,
   parameter  int RESEED_PERIOD = 65536,
   localparam int RND_W         = rnd_width(REF_N_RND, DOM_RND)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic [LFSR_W-1:0] seed_data,
   input  logic              reseed,
   input  logic              rnd_en,
   output logic [RND_W-1:0]  rnd,
   output logic              rnd_valid,
   output logic              reseed_req
);

   localparam int IDX_W = (RND_W > 1) ? $clog2(RND_W) : 1;
   localparam int CNT_W = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RND_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESEED_PERIOD);
   localparam bit               CNT_ON   = (RESEED_PERIOD != 0);

   rnd_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seed_fire;
   logic             lane_step;
   logic [RND_W-1:0] lane_lsb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEED;
         idx_q   <= {IDX_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      seed_ready = 1'b0;
      rnd_valid  = 1'b0;
      reseed_req = 1'b0;
      seed_fire  = 1'b0;
      lane_step  = 1'b0;

      case (state_q)
         SEED: begin
            seed_ready = 1'b1;
            // reseed drops a word offered in the same cycle
            seed_fire  = seed_valid && !reseed;
            if (seed_fire) begin
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
                  idx_d   = {IDX_W{1'b0}};
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         RUN: begin
            rnd_valid  = 1'b1;
            reseed_req = CNT_ON && (cnt_q == CNT_MAX);
            lane_step  = rnd_en && !reseed;
            if (lane_step && CNT_ON && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = SEED;
            idx_d   = {IDX_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      if (reseed) begin
         state_d = SEED;
         idx_d   = {IDX_W{1'b0}};
         cnt_d   = {CNT_W{1'b0}};
      end
   end

   for (genvar k = 0; k < RND_W; k++) begin : g_lane
      msk_lfsr32_lane u_lane (
         .clk      (clk),
         .rst      (rst),
         .load     (seed_fire && (idx_q == IDX_W'(k))),
         .load_val (seed_data),
         .step     (lane_step),
         .lsb      (lane_lsb[k])
      );
   end

   // Seed material must never reach the gadget, so rnd is held at zero outside RUN
   assign rnd = (state_q == RUN) ? lane_lsb : {RND_W{1'b0}};

endmodule

// File: tb/tb_msk_rnd_gen_g16mul.sv
// Self-checking bench for msk_rnd_gen_g16mul: fixed vector table, corner sequences, randomized model comparison.
module tb_msk_rnd_gen_g16mul;

   localparam int PER = 4;
   localparam int W   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          seed_valid = 1'b0;
   logic          reseed = 1'b0;
   logic          rnd_en = 1'b0;
   logic [31:0]   seed_data = 32'h0;
   logic          seed_ready, rnd_valid, reseed_req;
   logic [W-1:0]  rnd;

   int n_chk  = 0;
   int n_pass = 0;

   bit          m_run;
   int          m_idx, m_cnt;
   logic [31:0] m_lane [W];

   always #5 clk = ~clk;

   msk_rnd_gen_g16mul #(.d(2), .RESEED_PERIOD(PER)) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .seed_data  (seed_data),
      .reseed     (reseed),
      .rnd_en     (rnd_en),
      .rnd        (rnd),
      .rnd_valid  (rnd_valid),
      .reseed_req (reseed_req)
   );

   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic        rs;
      logic        en;
      logic        e_rdy;
      logic        e_vld;
      logic [7:0]  e_rnd;
      logic        e_req;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_idx = 0;
      m_cnt = 0;
      for (int k = 0; k < W; k++) m_lane[k] = 32'h0;
   endtask

   // Apply one cycle of inputs, advance the model by the same edge, compare all outputs.
   task automatic cyc(input logic sv, input logic [31:0] sd, input logic rs, input logic en);
      logic [31:0] nl [W];
      bit          nrun;
      int          nidx, ncnt;
      logic [W-1:0] er;
      seed_valid = sv;
      seed_data  = sd;
      reseed     = rs;
      rnd_en     = en;
      nl = m_lane; nrun = m_run; nidx = m_idx; ncnt = m_cnt;
      if (rs) begin
         nrun = 0; nidx = 0; ncnt = 0;
      end else if (!m_run) begin
         if (sv) begin
            nl[m_idx] = (sd == 32'h0) ? 32'h1 : sd;
            if (m_idx == W - 1) begin nrun = 1; nidx = 0; end
            else nidx = m_idx + 1;
         end
      end else if (en) begin
         for (int k = 0; k < W; k++) nl[k] = lfsr_next(m_lane[k]);
         if (m_cnt < PER) ncnt = m_cnt + 1;
      end
      @(posedge clk);
      #1;
      m_lane = nl; m_run = nrun; m_idx = nidx; m_cnt = ncnt;
      er = '0;
      if (m_run) for (int k = 0; k < W; k++) er[k] = m_lane[k][0];
      chk("model_rnd", 64'(rnd), 64'(er));
      chk("model_rnd_valid", 64'(rnd_valid), 64'(m_run));
      chk("model_seed_ready", 64'(seed_ready), 64'(!m_run));
      chk("model_reseed_req", 64'(reseed_req), 64'(m_cnt == PER));
   endtask

   task automatic add(input logic sv, input logic [31:0] sd, input logic en,
                      input logic rdy, input logic vld, input logic [7:0] r);
      vec_t v;
      v.sv = sv; v.sd = sd; v.rs = 1'b0; v.en = en;
      v.e_rdy = rdy; v.e_vld = vld; v.e_rnd = r; v.e_req = 1'b0;
      tbl.push_back(v);
   endtask

   initial begin
      model_reset();
      #3;
      chk("reset_rnd", 64'(rnd), 64'h0);
      chk("reset_rnd_valid", 64'(rnd_valid), 64'h0);
      chk("reset_seed_ready", 64'(seed_ready), 64'h1);
      chk("reset_reseed_req", 64'(reseed_req), 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Seeds 1,2,3,0(->1),4,5,6,7: LSBs give 0xAD, then lsb' = s1^s0 -> 0x6B, then s2^s1 -> 0x36
      add(1, 32'h1, 1, 1, 0, 8'h00);
      add(1, 32'h2, 1, 1, 0, 8'h00);
      add(1, 32'h3, 1, 1, 0, 8'h00);
      add(0, 32'h9, 1, 1, 0, 8'h00);
      add(1, 32'h0, 1, 1, 0, 8'h00);
      add(1, 32'h4, 0, 1, 0, 8'h00);
      add(1, 32'h5, 0, 1, 0, 8'h00);
      add(1, 32'h6, 1, 1, 0, 8'h00);
      add(1, 32'h7, 0, 0, 1, 8'hAD);
      add(0, 32'h0, 1, 0, 1, 8'h6B);
      add(0, 32'h0, 0, 0, 1, 8'h6B);
      add(0, 32'h0, 0, 0, 1, 8'h6B);
      add(0, 32'h0, 1, 0, 1, 8'h36);
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].sv, tbl[i].sd, tbl[i].rs, tbl[i].en);
         chk($sformatf("tbl%0d_seed_ready", i), 64'(seed_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_rnd_valid", i), 64'(rnd_valid), 64'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_rnd", i), 64'(rnd), 64'(tbl[i].e_rnd));
         chk($sformatf("tbl%0d_reseed_req", i), 64'(reseed_req), 64'(tbl[i].e_req));
         if (i == 8) chk("lane3_zero_fix", 64'(dut.g_lane[3].u_lane.state_q), 64'h1);
      end

      // Third advance of lane 0 and the reseed period boundary (advances 3, 4, then saturated)
      cyc(0, 0, 0, 1);
      chk("lane0_after_3_steps", 64'(dut.g_lane[0].u_lane.state_q), 64'h6018_0001);
      chk("rnd0_4th_bit", 64'(rnd[0]), 64'h1);
      chk("req_after_3_adv", 64'(reseed_req), 64'h0);
      cyc(0, 0, 0, 1);
      chk("req_after_4_adv", 64'(reseed_req), 64'h1);
      cyc(0, 0, 0, 1);
      chk("req_saturated", 64'(reseed_req), 64'h1);
      chk("rnd_valid_after_req", 64'(rnd_valid), 64'h1);
      cyc(0, 0, 1, 1);
      chk("reseed_req_clear", 64'(reseed_req), 64'h0);
      chk("reseed_rnd_valid", 64'(rnd_valid), 64'h0);
      chk("reseed_seed_ready", 64'(seed_ready), 64'h1);
      chk("reseed_rnd_zero", 64'(rnd), 64'h0);
      chk("reseed_no_step", 64'(dut.g_lane[0].u_lane.state_q), 64'(m_lane[0]));

      // reseed collides with the 8th handshake: word dropped, index back to lane 0
      for (int i = 0; i < 7; i++) cyc(1, 32'h100 + 32'(i), 0, 0);
      cyc(1, 32'hDEAD_BEEF, 1, 1);
      chk("collide_seed_ready", 64'(seed_ready), 64'h1);
      chk("collide_rnd_valid", 64'(rnd_valid), 64'h0);
      chk("collide_lane7_kept", 64'(dut.g_lane[7].u_lane.state_q), 64'(m_lane[7]));
      cyc(1, 32'hCAFE_0001, 0, 0);
      chk("collide_idx0", 64'(dut.g_lane[0].u_lane.state_q), 64'hCAFE_0001);
      chk("collide_still_seed", 64'(rnd_valid), 64'h0);

      // Asynchronous reset after 5 words, then a fresh load must reproduce the table's sequence
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 32'h55 + 32'(i), 0, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_rnd", 64'(rnd), 64'h0);
      chk("rst_rnd_valid", 64'(rnd_valid), 64'h0);
      chk("rst_seed_ready", 64'(seed_ready), 64'h1);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1, 32'h1, 0, 0); cyc(1, 32'h2, 0, 0); cyc(1, 32'h3, 0, 0); cyc(1, 32'h0, 0, 0);
      cyc(1, 32'h4, 0, 0); cyc(1, 32'h5, 0, 0); cyc(1, 32'h6, 0, 0); cyc(1, 32'h7, 0, 0);
      chk("reload_rnd0", 64'(rnd), 64'hAD);
      cyc(0, 0, 0, 1);
      chk("reload_rnd1", 64'(rnd), 64'h6B);
      cyc(0, 0, 0, 1);
      chk("reload_rnd2", 64'(rnd), 64'h36);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         cyc(1'($urandom_range(1, 0)),
             ($urandom_range(7, 0) == 0) ? 32'h0 : $urandom,
             ($urandom_range(63, 0) == 0),
             ($urandom_range(3, 0) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
